// File: rtl/data_path.sv
`default_nettype none
// =============================================================================
// data_path : 32-bit bus datapath with GPR file, HI/LO, Y/Z ALU and ROM.
// Revision  : 1.0
// =============================================================================
module data_path #(
  parameter int MEM_WORDS = 512
) (
  input logic       clock,
  input logic       clear,
  input logic       read,
  input logic       Gra,
  input logic       Grb,
  input logic       Grc,
  input logic       Rin,
  input logic       Rout,
  input logic       BAout,
  input logic       HIin,
  input logic       HIout,
  input logic       LOin,
  input logic       LOout,
  input logic       Zin,
  input logic       Zhighout,
  input logic       Zlowout,
  input logic       Yin,
  input logic       MDRin,
  input logic       MDRout,
  input logic       MARin,
  input logic       PCin,
  input logic       PCout,
  input logic       IRin,
  input logic       IncPC,
  input logic       Cout,
  input logic [4:0] opcode
);

  localparam int ADDR_W = (MEM_WORDS > 2) ? $clog2(MEM_WORDS) : 1;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  logic [31:0] r [16];
  logic [31:0] pc, ir, mar, mdr, y, hi, lo;
  logic [63:0] z;
  logic [31:0] bus;

  logic [3:0]  sel_idx;
  logic [31:0] c_ext;
  logic [31:0] mem_data;
  logic [ADDR_W-1:0] mem_addr;
  logic        unused_bits;

  assign sel_idx = ({4{Gra}} & ir[26:23]) | ({4{Grb}} & ir[22:19]) | ({4{Grc}} & ir[18:15]);
  assign c_ext   = {{13{ir[18]}}, ir[18:0]};
  assign mem_addr = mar[ADDR_W-1:0];
  assign unused_bits = ^{mar[31:ADDR_W], ir[31:27]};

  // Read-only memory: two preloaded words, everything else reads as zero.
  always_comb begin
    mem_data = '0;
    if (mem_addr == ADDR_W'(0))
      mem_data = 32'h0900_0095;
    else if (mem_addr == ADDR_W'(1))
      mem_data = 32'h0990_0067;
  end

  always_comb begin
    bus = '0;
    if (Rout)          bus = r[sel_idx];
    else if (BAout)    bus = (sel_idx == 4'd0) ? 32'd0 : r[sel_idx];
    else if (HIout)    bus = hi;
    else if (LOout)    bus = lo;
    else if (Zhighout) bus = z[63:32];
    else if (Zlowout)  bus = z[31:0];
    else if (PCout)    bus = pc;
    else if (MDRout)   bus = mdr;
    else if (Cout)     bus = c_ext;
  end

  logic [31:0]        a, b;
  logic [4:0]         shamt;
  logic [5:0]         shinv;
  logic signed [63:0] prod;
  logic signed [31:0] quot, rem;
  logic [63:0]        alu_out;

  assign a     = y;
  assign b     = bus;
  assign shamt = b[4:0];
  assign shinv = 6'd32 - {1'b0, shamt};
  assign prod  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign quot  = (b == 32'd0) ? 32'sd0 : $signed(a) / $signed(b);
  assign rem   = (b == 32'd0) ? 32'sd0 : $signed(a) % $signed(b);

  always_comb begin
    alu_out = '0;
    if (IncPC) begin
      alu_out = {32'd0, b + 32'd1};
    end else begin
      case (opcode)
        OP_ADD:  alu_out = {32'd0, a + b};
        OP_SUB:  alu_out = {32'd0, a - b};
        OP_AND:  alu_out = {32'd0, a & b};
        OP_OR:   alu_out = {32'd0, a | b};
        OP_ROR:  alu_out = {32'd0, (a >> shamt) | (a << shinv)};
        OP_ROL:  alu_out = {32'd0, (a << shamt) | (a >> shinv)};
        OP_SHR:  alu_out = {32'd0, a >> shamt};
        OP_SHRA: alu_out = {32'd0, 32'($signed(a) >>> shamt)};
        OP_SHL:  alu_out = {32'd0, a << shamt};
        OP_MUL:  alu_out = prod;
        OP_DIV:  alu_out = {rem, quot};
        OP_NEG:  alu_out = {32'd0, 32'd0 - b};
        OP_NOT:  alu_out = {32'd0, ~b};
        default: alu_out = '0;
      endcase
    end
  end

  // All state advances on the falling edge of clock.
  always_ff @(negedge clock) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) r[i] <= '0;
      pc  <= '0;
      ir  <= '0;
      mar <= '0;
      mdr <= '0;
      y   <= '0;
      z   <= '0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      if (Rin)   r[sel_idx] <= bus;
      if (PCin)  pc  <= bus;
      if (IRin)  ir  <= bus;
      if (MARin) mar <= bus;
      if (MDRin) mdr <= read ? mem_data : bus;
      if (Yin)   y   <= bus;
      if (Zin)   z   <= alu_out;
      if (HIin)  hi  <= bus;
      if (LOin)  lo  <= bus;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_path.sv
`default_nettype none
// =============================================================================
// tb_data_path : scoreboard bench for data_path with randomized ALU checks.
// Revision     : 1.0
// =============================================================================
module tb_data_path;

  localparam int SEL_PC  = 16;
  localparam int SEL_IR  = 17;
  localparam int SEL_MAR = 18;
  localparam int SEL_MDR = 19;
  localparam int SEL_Y   = 20;
  localparam int SEL_Z   = 21;
  localparam int SEL_HI  = 22;
  localparam int SEL_LO  = 23;
  localparam int SEL_BUS = 24;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_MUL = 5'b10000;

  logic clock = 1'b0;
  logic clear, read, Gra, Grb, Grc, Rin, Rout, BAout;
  logic HIin, HIout, LOin, LOout, Zin, Zhighout, Zlowout;
  logic Yin, MDRin, MDRout, MARin, PCin, PCout, IRin, IncPC, Cout;
  logic [4:0] opcode;

  always #5 clock = ~clock;

  data_path #(.MEM_WORDS(512)) dut (
    .clock(clock), .clear(clear), .read(read),
    .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
    .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .Yin(Yin), .MDRin(MDRin), .MDRout(MDRout), .MARin(MARin),
    .PCin(PCin), .PCout(PCout), .IRin(IRin),
    .IncPC(IncPC), .Cout(Cout), .opcode(opcode)
  );

  typedef struct {
    int          sel;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [4:0] op_table [13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111,
                                5'b10000, 5'b10001, 5'b10010};

  function automatic logic [63:0] peek(input int sel);
    case (sel)
      SEL_PC:  return {32'd0, dut.pc};
      SEL_IR:  return {32'd0, dut.ir};
      SEL_MAR: return {32'd0, dut.mar};
      SEL_MDR: return {32'd0, dut.mdr};
      SEL_Y:   return {32'd0, dut.y};
      SEL_Z:   return dut.z;
      SEL_HI:  return {32'd0, dut.hi};
      SEL_LO:  return {32'd0, dut.lo};
      SEL_BUS: return {32'd0, dut.bus};
      default: return {32'd0, dut.r[sel[3:0]]};
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      SEL_PC:  return "PC";
      SEL_IR:  return "IR";
      SEL_MAR: return "MAR";
      SEL_MDR: return "MDR";
      SEL_Y:   return "Y";
      SEL_Z:   return "Z";
      SEL_HI:  return "HI";
      SEL_LO:  return "LO";
      SEL_BUS: return "bus";
      default: return $sformatf("R%0d", sel);
    endcase
  endfunction

  // Reference ALU computed straight from the operation definitions.
  function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int          sa, sbv, q, rm;
    longint      p;
    logic [31:0] x;
    int          n;
    sa = a; sbv = b; n = int'(b[4:0]); x = a;
    case (op)
      5'b00011: return {32'd0, a + b};
      5'b00100: return {32'd0, a - b};
      5'b00101: return {32'd0, a & b};
      5'b00110: return {32'd0, a | b};
      5'b00111: begin for (int k = 0; k < n; k++) x = {x[0], x[31:1]}; return {32'd0, x}; end
      5'b01000: begin for (int k = 0; k < n; k++) x = {x[30:0], x[31]}; return {32'd0, x}; end
      5'b01001: return {32'd0, a >> n};
      5'b01010: return {32'd0, 32'(sa >>> n)};
      5'b01011: return {32'd0, a << n};
      5'b01111: begin
        if (b == 32'd0) return 64'd0;
        q = sa / sbv; rm = sa % sbv;
        return {32'(rm), 32'(q)};
      end
      5'b10000: begin p = longint'(sa) * longint'(sbv); return 64'(p); end
      5'b10001: return {32'd0, 32'd0 - b};
      5'b10010: return {32'd0, ~b};
      default:  return 64'd0;
    endcase
  endfunction

  // Monitor: compares every queued expectation away from the falling (active) edge.
  always @(posedge clock) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [63:0] got;
      e = sb.pop_front();
      got = peek(e.sel);
      vectors++;
      if (got !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h, expected %h", sel_name(e.sel), got, e.val);
      end
    end
  end

  task automatic push(input int sel, input logic [63:0] v);
    sb.push_back('{sel, v});
  endtask

  task automatic idle();
    {clear, read, Gra, Grb, Grc, Rin, Rout, BAout, HIin, HIout, LOin, LOout, Zin,
     Zhighout, Zlowout, Yin, MDRin, MDRout, MARin, PCin, PCout, IRin, IncPC, Cout} = '0;
    opcode = 5'd0;
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic expect_all_zero();
    for (int i = 0; i < 24; i++) push(i, 64'd0);
  endtask

  task automatic fetch();
    idle(); PCout = 1; MARin = 1; IncPC = 1; Zin = 1; tick();
    idle(); read = 1; Zlowout = 1; PCin = 1; MDRin = 1; tick();
    idle(); MDRout = 1; IRin = 1; tick();
  endtask

  task automatic ldi();
    idle(); Grb = 1; BAout = 1; Yin = 1; tick();
    idle(); Cout = 1; Zin = 1; opcode = OP_ADD; tick();
    idle(); Zlowout = 1; Gra = 1; Rin = 1; tick();
  endtask

  // Leaves v in Z[31:0] by doubling and incrementing through the ALU.
  task automatic build(input logic [31:0] v);
    bit started;
    started = 1'b0;
    idle(); Zin = 1; tick();
    for (int i = 31; i >= 0; i--) begin
      if (started) begin
        idle(); Zlowout = 1; Yin = 1; tick();
        idle(); Zlowout = 1; Zin = 1; opcode = OP_ADD; tick();
      end
      if (v[i]) begin
        idle(); Zlowout = 1; IncPC = 1; Zin = 1; tick();
        started = 1'b1;
      end
    end
  endtask

  task automatic op_test(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    build(b);
    idle(); Zlowout = 1; LOin = 1; tick();
    build(a);
    idle(); Zlowout = 1; Yin = 1; tick();
    idle(); LOout = 1; opcode = op; Zin = 1; tick();
    push(SEL_LO, {32'd0, b});
    push(SEL_Z, alu_ref(op, a, b));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    logic [4:0]  rop;
    int          waited;

    idle(); clear = 1; tick();
    expect_all_zero();

    fetch();
    push(SEL_PC, 64'd1); push(SEL_IR, 64'h0900_0095);
    push(SEL_MAR, 64'd0); push(SEL_MDR, 64'h0900_0095);
    ldi();
    push(SEL_Y, 64'd0); push(2, 64'h95); push(SEL_Z, 64'h95);

    fetch();
    ldi();
    push(SEL_MAR, 64'd1); push(SEL_PC, 64'd2); push(SEL_IR, 64'h0990_0067);
    push(SEL_Y, 64'h95); push(3, 64'hFC);

    // IR now has Rc = 0, so Grc addresses R0.
    idle(); Zlowout = 1; Grc = 1; Rin = 1; tick();
    push(0, 64'hFC);
    idle(); Grc = 1; BAout = 1; push(SEL_BUS, 64'd0); tick();
    idle(); Grc = 1; Rout = 1; push(SEL_BUS, 64'hFC); tick();

    idle(); Zlowout = 1; HIin = 1; LOin = 1; Yin = 1; MARin = 1; tick();
    push(SEL_HI, 64'hFC); push(SEL_LO, 64'hFC); push(SEL_Y, 64'hFC); push(SEL_MAR, 64'hFC);
    idle(); PCout = 1; LOin = 1; tick();
    idle(); HIout = 1; LOout = 1; PCout = 1; push(SEL_BUS, 64'hFC); tick();
    idle(); LOout = 1; PCout = 1; MDRout = 1; push(SEL_BUS, 64'd2); tick();

    idle(); PCout = 1; IncPC = 1; opcode = OP_MUL; Zin = 1; tick();
    push(SEL_Z, 64'd3);
    idle(); PCout = 1; opcode = 5'b00000; Zin = 1; tick();
    push(SEL_Z, 64'd0);
    idle(); PCout = 1; Yin = 1; tick();
    idle(); PCout = 1; opcode = 5'b11111; Zin = 1; tick();
    push(SEL_Z, 64'd0);

    build(32'h0007_FFFF);
    idle(); Zlowout = 1; IRin = 1; tick();
    idle(); Cout = 1; push(SEL_BUS, 64'hFFFF_FFFF); tick();

    op_test(OP_MUL, 32'hFFFF_FFFF, 32'd2);
    idle(); Zhighout = 1; push(SEL_BUS, 64'hFFFF_FFFF); tick();
    op_test(OP_DIV, 32'd7, 32'd2);
    op_test(OP_DIV, 32'h1234_5678, 32'd0);
    op_test(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    op_test(OP_ADD, 32'hFFFF_FFFF, 32'd1);

    for (int t = 0; t < 24; t++) begin
      rop = op_table[$urandom_range(0, 12)];
      ra = $urandom;
      rb = $urandom;
      if (rop == OP_DIV && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      op_test(rop, ra, rb);
    end

    // Reset in the middle of activity must win over every load strobe.
    idle(); Zlowout = 1; Gra = 1; Rin = 1; PCin = 1; Yin = 1; LOin = 1; clear = 1; tick();
    expect_all_zero();

    fetch();
    push(SEL_IR, 64'h0900_0095); push(SEL_PC, 64'd1);
    idle();

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clock);
      waited++;
    end
    #1;
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_path.md
DATA_PATH -- requirements
Module: data_path

Interface
REQ-001 Parameter MEM_WORDS, default 512, meaning internal memory depth in 32-bit words, addressed by MAR[8:0].
REQ-002 clock  in  1  single system clock; all state updates on its falling edge.
REQ-003 clear  in  1  synchronous, active-high reset, sampled on the falling edge of clock.
REQ-004 read  in  1  1: MDR input mux selects memory[MAR]; 0: selects bus.
REQ-005 Gra, Grb, Grc  in  1 each  select register field Ra/Rb/Rc of IR.
REQ-006 Rin, Rout, BAout  in  1 each  write, read, and base-address read of the selected GPR.
REQ-007 HIin, HIout, LOin, LOout  in  1 each  HI/LO register load and bus drive.
REQ-008 Zin, Zhighout, Zlowout  in  1 each  Z load and drive of Z[63:32] or Z[31:0].
REQ-009 Yin, MDRin, MDRout, MARin, PCin, PCout, IRin  in  1 each  register load and bus-drive strobes.
REQ-010 IncPC  in  1  ALU forces result = bus + 1.
REQ-011 Cout  in  1  drive sign-extended IR[18:0] onto bus.
REQ-012 opcode  in  5  ALU operation select.
REQ-013 No output ports; all state is internal and hierarchically observable (R0-R15, PC, IR, MAR, MDR, Y, Z, HI, LO, bus).

Function
REQ-014 32-bit internal bus; registers R0-R15, PC, IR, MAR, MDR, Y, HI, LO are 32-bit; Z is 64-bit.
REQ-015 Bus source priority: Rout/BAout GPR, HI, LO, Zhigh, Zlow, PC, MDR, C; bus = 0 when no source asserted.
REQ-016 IR fields: Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15], C = IR[18:0] sign-extended from bit 18.
REQ-017 Select-encode: register index = OR of (Gra&Ra, Grb&Rb, Grc&Rc); Rin loads that GPR from bus; Rout drives it.
REQ-018 BAout drives selected GPR, except drives 0 when selected index is 0; R0 is otherwise an ordinary writable register.
REQ-019 Memory read is combinational from MAR[8:0]; MDR loads on MDRin from the read mux; memory has no write path.
REQ-020 Memory initial contents: word 0 = 0x09000095, word 1 = 0x09900067, all others 0.
REQ-021 ALU: A = Y, B = bus; Z loads on Zin; 32-bit results go to Z[31:0] with Z[63:32] = 0.
REQ-022 Opcodes: 00011 add, 00100 sub (A-B), 00101 and, 00110 or, 00111 ror, 01000 rol, 01001 shr, 01010 shra, 01011 shl (shift/rotate by B[4:0]), 10001 neg B, 10010 not B.
REQ-023 Opcode 10000 mul: Z = signed A*B (64-bit); 01111 div: Z[31:0] = signed A/B quotient, Z[63:32] = remainder; B = 0 gives Z = 0.
REQ-024 IncPC overrides opcode: Z = {32'b0, bus+1}; any other or undriven (X/Z) opcode gives result 0.
REQ-025 Add/sub wrap modulo 2^32; no flags.
REQ-026 Simultaneous load strobes all capture the same bus value on the same falling edge.

Reset
REQ-027 clear=1 at a falling edge sets R0-R15, PC, IR, MAR, MDR, Y, Z, HI, LO to 0; memory unchanged; clear overrides all load strobes.

Verification
REQ-028 Fetch: after reset, PCout+MARin+IncPC+Zin, then read+Zlowout+PCin+MDRin, then MDRout+IRin -> PC=1, IR=0x09000095.
REQ-029 ldi R2,0x95(R0): Grb+BAout+Yin; Cout+Zin, opcode=00011; Zlowout+Gra+Rin -> Y=0, R2=0x00000095.
REQ-030 Second fetch+ldi (word 1, Rb=R2, BAout): R3=0x000000FC, PC=2.
REQ-031 IR[18]=1 with C=0x7FFFF, Cout -> bus=0xFFFFFFFF.
REQ-032 Y=0xFFFFFFFF, bus=2, opcode 10000, Zin -> Z=0xFFFFFFFF_FFFFFFFE; opcode 01111 with Y=7, bus=2 -> Zlo=3, Zhi=1.
REQ-033 clear asserted mid-sequence with Rin active -> all registers 0 after the edge.
